// File: rtl/seq_mult_arbiter.sv
// Round-robin scheduler sharing one external sequential multiplier among NREQ clients.
// Define SEQ_MULT_ARB_TIMEOUT_EN to give up on a stuck multiplier after TIMEOUT busy cycles.
module seq_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    p_out,
  output logic              busy,
  output logic              err,
  output logic              mul_load,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  input  logic              mul_rdy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("seq_mult_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BUSY,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [2*W-1:0]    p_q, p_d;
  logic              busy_q, busy_d;
  logic              load_q, load_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              first_q, first_d;
  logic              tmo;

  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;

`ifdef SEQ_MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign tmo = (cnt_q == CW'(TIMEOUT - 1));
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  // Scan from the pointer so the last winner drops to lowest priority.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    p_d     = p_q;
    busy_d  = busy_q;
    load_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    first_d = 1'b0;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          gnt_d   = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d   = win_idx;
          a_d     = a_bus[int'(win_idx)*W +: W];
          b_d     = b_bus[int'(win_idx)*W +: W];
          load_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        first_d = 1'b1;
        state_d = S_BUSY;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_BUSY: begin
        // rdy in the first busy cycle still belongs to the previous op
        if (!first_q && mul_rdy) begin
          p_d     = mul_p;
          done_d  = req & gnt_q;
          state_d = S_DONE;
        end else if (tmo) begin
          p_d     = '0;
          done_d  = req & gnt_q;
          state_d = S_DONE;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      first_q <= 1'b0;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign p_out    = p_q;
  assign busy     = busy_q;
  assign mul_load = load_q;
  assign mul_a    = a_q;
  assign mul_b    = b_q;

endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Bench for seq_mult_arbiter with a behavioural sequential multiplier model.
// Round-robin order and products come from a spec-level model kept here.
module tb_seq_mult_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TO   = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] a_bus = '0;
  logic [NREQ*W-1:0] b_bus = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*W-1:0]    p_out;
  logic              busy;
  logic              err;
  logic              mul_load;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_p = '0;
  logic              mul_rdy = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] am [NREQ];
  logic [W-1:0] bm [NREQ];
  int           ptr_m = 0;

  seq_mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .done(done), .p_out(p_out),
    .busy(busy), .err(err), .mul_load(mul_load),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .mul_rdy(mul_rdy)
  );

  always #5 clk = ~clk;

  // Multiplier model: restart is seen one cycle late, so rdy is stale
  // during the arbiter's first busy cycle; junk on mul_p until ready.
  logic           m_ld = 1'b0;
  int             m_cnt = 0;
  logic [2*W-1:0] m_prod = '0;
  bit             stuck = 1'b0;

  always @(posedge clk) begin
    m_ld <= mul_load;
    if (m_ld) begin
      mul_rdy <= 1'b0;
      m_cnt   <= 2*W - 1;
      m_prod  <= $signed(mul_a) * $signed(mul_b);
      mul_p   <= 16'($urandom);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      mul_p <= 16'($urandom);
      if (m_cnt == 1 && !stuck) begin
        mul_rdy <= 1'b1;
        mul_p   <= m_prod;
      end
    end
  end

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic signed [2*W-1:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  function automatic int winner(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    am[i] = a;
    bm[i] = b;
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
  endtask

  task automatic wait_done(input int budget, output logic [NREQ-1:0] d,
                           output int cyc);
    bit seen;
    seen = 1'b0;
    d    = '0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done !== '0) begin
        d    = done;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++)
      set_ops(i, 8'($urandom), 8'($urandom));
    reset = 1'b0;
    req   = '1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl gnt=%b done=%b busy=%b want 0", gnt, done, busy);
    end
    checks++;
    if (p_out !== '0 || err !== 1'b0 || mul_load !== 1'b0) begin
      errors++;
      $display("FAIL reset_out p_out=%h err=%b mul_load=%b want 0",
               p_out, err, mul_load);
    end
    checks++;
    if (mul_a !== '0 || mul_b !== '0) begin
      errors++;
      $display("FAIL reset_ops mul_a=%h mul_b=%h want 0", mul_a, mul_b);
    end
    req   = '0;
    reset = 1'b1;
    ptr_m = 0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] d;
    int cyc;
    set_ops(0, 8'd3, 8'hFB);
    @(negedge clk);
    req = 4'b0001;
    wait_done(60, d, cyc);
    checks++;
    if (d !== 4'b0001) begin
      errors++;
      $display("FAIL single_done got=%b want=0001", d);
    end
    checks++;
    if (p_out !== 16'hFFF1) begin
      errors++;
      $display("FAIL single_p got=%h want=fff1", p_out);
    end
    checks++;
    if (cyc != 19) begin
      errors++;
      $display("FAIL single_latency got=%0d want=19", cyc);
    end
    checks++;
    if (gnt !== 4'b0001 || err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gnt gnt=%b err=%b busy=%b want 0001/0/1",
               gnt, err, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
      errors++;
      $display("FAIL single_after gnt=%b busy=%b done=%b want 0",
               gnt, busy, done);
    end
    ptr_m = 1;
  endtask

  task automatic test_corner();
    logic [W-1:0]   ta [2];
    logic [W-1:0]   tb [2];
    logic [2*W-1:0] tp [2];
    logic [NREQ-1:0] d;
    int cyc;
    ta[0] = 8'h80; tb[0] = 8'h80; tp[0] = 16'h4000;
    ta[1] = 8'h7F; tb[1] = 8'h80; tp[1] = 16'hC080;
    for (int n = 0; n < 2; n++) begin
      set_ops(0, ta[n], tb[n]);
      req = 4'b0001;
      wait_done(60, d, cyc);
      checks++;
      if (d !== 4'b0001 || p_out !== tp[n]) begin
        errors++;
        $display("FAIL corner%0d done=%b p=%h want 0001 %h", n, d, p_out, tp[n]);
      end
      req = '0;
      @(negedge clk);
    end
    ptr_m = 1;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] d;
    int cyc, w;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_ops(i, 8'($urandom), 8'($urandom));
    req = '1;
    for (int n = 0; n < 5; n++) begin
      w = winner(req, ptr_m);
      wait_done(60, d, cyc);
      checks++;
      if (d !== oh(w) || p_out !== prod(am[w], bm[w]) || err !== 1'b0) begin
        errors++;
        $display("FAIL rr%0d done=%b p=%h err=%b want %b %h 0",
                 n, d, p_out, err, oh(w), prod(am[w], bm[w]));
      end
      ptr_m = (w + 1) % NREQ;
      set_ops(w, 8'($urandom), 8'($urandom));
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    int cyc, bad1, fell;
    logic prev_busy;
    do_reset();
    set_ops(1, 8'($urandom), 8'($urandom));
    set_ops(2, 8'($urandom), 8'($urandom));
    req = 4'b0010;
    repeat (6) @(negedge clk);
    req = 4'b0100;
    cyc = 0; bad1 = 0; fell = 0;
    prev_busy = busy;
    while (done === '0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done[1] === 1'b1) bad1++;
      if (prev_busy && !busy && fell == 0) begin
        fell = 1;
        checks++;
        if (p_out !== prod(am[1], bm[1])) begin
          errors++;
          $display("FAIL withdraw_p got=%h want=%h", p_out, prod(am[1], bm[1]));
        end
      end
      prev_busy = busy;
    end
    checks++;
    if (bad1 != 0 || fell == 0) begin
      errors++;
      $display("FAIL withdraw_nodone pulses=%0d idle_seen=%0d want 0 1",
               bad1, fell);
    end
    checks++;
    if (done !== 4'b0100 || p_out !== prod(am[2], bm[2])) begin
      errors++;
      $display("FAIL withdraw_next done=%b p=%h want 0100 %h",
               done, p_out, prod(am[2], bm[2]));
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] d;
    int cyc, bad;
    do_reset();
    set_ops(0, 8'($urandom), 8'($urandom));
    req = 4'b0001;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt, done, p_out, busy, err, mul_load, mul_a, mul_b} !== '0) begin
      errors++;
      $display("FAIL midreset gnt=%b done=%b p=%h busy=%b ld=%b a=%h b=%h",
               gnt, done, p_out, busy, mul_load, mul_a, mul_b);
    end
    reset = 1'b1;
    req   = '0;
    ptr_m = 0;
    bad   = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== '0 || p_out !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_stale bad_cycles=%0d want 0", bad);
    end
    set_ops(0, 8'($urandom), 8'($urandom));
    req = 4'b0001;
    wait_done(60, d, cyc);
    checks++;
    if (d !== 4'b0001 || p_out !== prod(am[0], bm[0])) begin
      errors++;
      $display("FAIL midreset_fresh done=%b p=%h want 0001 %h",
               d, p_out, prod(am[0], bm[0]));
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    do_reset();
    set_ops(0, 8'($urandom), 8'($urandom));
    req = 4'b0001;
`ifdef SEQ_MULT_ARB_TIMEOUT_EN
    begin
      logic [NREQ-1:0] d;
      int cyc;
      wait_done(60, d, cyc);
      checks++;
      if (d !== 4'b0001 || cyc != TO + 2) begin
        errors++;
        $display("FAIL timeout_done got=%b at %0d want 0001 at %0d",
                 d, cyc, TO + 2);
      end
      checks++;
      if (err !== 1'b1 || p_out !== '0) begin
        errors++;
        $display("FAIL timeout_err err=%b p=%h want 1 0000", err, p_out);
      end
    end
`else
    begin
      int nb, nd;
      nb = 0; nd = 0;
      repeat (2) @(negedge clk);
      repeat (60) begin
        @(negedge clk);
        if (busy !== 1'b1) nb++;
        if (done !== '0 || err !== 1'b0) nd++;
      end
      checks++;
      if (nb != 0) begin
        errors++;
        $display("FAIL stuck_busy idle_cycles=%0d want 0", nb);
      end
      checks++;
      if (nd != 0) begin
        errors++;
        $display("FAIL stuck_nodone done_cycles=%0d want 0", nd);
      end
    end
`endif
    stuck = 1'b0;
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_corner();
    test_round_robin();
    test_withdraw();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
